mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - SRAM / memory-mapped I/O access sequencer for the CPU memory port
//
// Purpose:
//   Turns level read/write requests from the control unit into timed, active-low
//   SRAM strobe sequences, or into a single-cycle switch read / hex-display write
//   when the latched address hits IO_ADDR. Address and write data are latched
//   when the access leaves IDLE, so MAR/MDR may change freely mid-access.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   Mem_OE, Mem_WE    level read / write requests (write wins when both high)
//   MAR, MDR          access address, write data
//   Switches          board switches, returned for a read at IO_ADDR
//   SRAM_DQ_in        data returning from the SRAM
//   Data_to_CPU       registered read data
//   Mem_Ready         access complete (high in DONE)
//   SRAM_ADDR         zero-extended latched address
//   SRAM_*_N          active-low chip/output/write/byte strobes
//   SRAM_DQ_out       latched write data
//   SRAM_DQ_oe        drive enable for SRAM_DQ_out
//   HEX_Data          hex-display register, written at IO_ADDR

module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] Switches,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic [15:0] HEX_Data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_IO   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Strobe phase ends on the cycle the counter shows this value.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mdr_q, mdr_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] hex_q, hex_d;
  logic        req_held;

  // DONE waits on whichever request started the access, not on both.
  assign req_held = is_wr_q ? Mem_WE : Mem_OE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    is_wr_d = is_wr_q;
    data_d  = data_q;
    hex_d   = hex_q;
    case (state_q)
      S_IDLE: begin
        if (Mem_WE || Mem_OE) begin
          addr_d  = MAR;
          cnt_d   = 4'd0;
          is_wr_d = Mem_WE;
          if (Mem_WE) begin
            mdr_d = MDR;
          end
          if (MAR == IO_ADDR) begin
            state_d = S_IO;
          end else if (Mem_WE) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          data_d  = SRAM_DQ_in;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_IO: begin
        if (is_wr_q) begin
          hex_d = mdr_q;
        end else begin
          data_d = Switches;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!req_held) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      mdr_q   <= 16'd0;
      is_wr_q <= 1'b0;
      data_q  <= 16'd0;
      hex_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      is_wr_q <= is_wr_d;
      data_q  <= data_d;
      hex_q   <= hex_d;
    end
  end

  // Strobes are pure decodes of the state register, so they change only on
  // clock edges and are all inactive in IDLE, IO and DONE.
  logic sram_active;
  assign sram_active = (state_q == S_RD) || (state_q == S_WR);

  assign Mem_Ready   = (state_q == S_DONE);
  assign SRAM_ADDR   = {4'h0, addr_q};
  assign SRAM_CE_N   = !sram_active;
  assign SRAM_OE_N   = (state_q != S_RD);
  assign SRAM_WE_N   = (state_q != S_WR);
  assign SRAM_LB_N   = !sram_active;
  assign SRAM_UB_N   = !sram_active;
  assign SRAM_DQ_oe  = (state_q == S_WR);
  assign SRAM_DQ_out = mdr_q;
  assign Data_to_CPU = data_q;
  assign HEX_Data    = hex_q;

endmodule
